// File: rtl/bloco_controle.sv
// bloco_controle: Moore control FSM for the polynomial datapath (bloco operativo).
// It sequences the datapath's operand muxes, ALU operation and register loads so
// that the datapath's S register ends up holding the selected result.
//   mode 0: y = a*x^2 + b*x + c   (S = ((a*x)+b)*X + c)
//   mode 1: y = a*c*x^2           (H = a*x, S = c*x, S = S*H)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request a computation (sampled only in IDLE)
//   mode            polynomial select, captured when start is accepted
//   m0, m1, m2      operand mux selects for the datapath
//   h               ALU operation (0: A+B, 1: A*B)
//   lx, ls, lh      X / S / H register load enables
//   busy            high while a computation is in progress
//   done            one-cycle pulse, datapath result is final
module bloco_controle (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       busy,
    output logic       done
);

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [3:0] {
        S_IDLE, S_LX, S_M1, S_A1, S_M2, S_A2, S_HM, S_SM, S_FM, S_DN
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] m0;
        logic [SEL_W-1:0] m1;
        logic [SEL_W-1:0] m2;
        logic             h;
        logic             lx;
        logic             ls;
        logic             lh;
        logic             busy;
        logic             done;
    } ctrl_t;

    state_t            state_q;
    logic [MODE_W-1:0] mode_q;
    ctrl_t             ctrl_q;

    // Successor state; start only matters in IDLE, mode only in LX.
    function automatic state_t next_of(input state_t s, input logic st,
                                       input logic [MODE_W-1:0] md);
        state_t n;
        n = s;
        case (s)
            S_IDLE:  n = st ? S_LX : S_IDLE;
            S_LX:    n = (md != MODE_W'(0)) ? S_HM : S_M1;
            S_M1:    n = S_A1;
            S_A1:    n = S_M2;
            S_M2:    n = S_A2;
            S_A2:    n = S_DN;
            S_HM:    n = S_SM;
            S_SM:    n = S_FM;
            S_FM:    n = S_DN;
            S_DN:    n = S_IDLE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Output decode for a state; anything not set stays 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_LX: begin
                c.lx = 1'b1; c.busy = 1'b1;
            end
            S_M1: begin                                   // S = a*x
                c.h = 1'b1; c.ls = 1'b1; c.busy = 1'b1;
            end
            S_A1: begin                                   // S = S+b
                c.m0 = SEL_W'(2); c.m1 = SEL_W'(2); c.m2 = SEL_W'(1);
                c.ls = 1'b1; c.busy = 1'b1;
            end
            S_M2: begin                                   // S = S*X
                c.m1 = SEL_W'(2);
                c.h = 1'b1; c.ls = 1'b1; c.busy = 1'b1;
            end
            S_A2: begin                                   // S = S+c
                c.m0 = SEL_W'(3); c.m1 = SEL_W'(2); c.m2 = SEL_W'(1);
                c.ls = 1'b1; c.busy = 1'b1;
            end
            S_HM: begin                                   // H = a*x
                c.h = 1'b1; c.lh = 1'b1; c.busy = 1'b1;
            end
            S_SM: begin                                   // S = c*x
                c.m0 = SEL_W'(3);
                c.h = 1'b1; c.ls = 1'b1; c.busy = 1'b1;
            end
            S_FM: begin                                   // S = S*H
                c.m1 = SEL_W'(2); c.m2 = SEL_W'(3);
                c.h = 1'b1; c.ls = 1'b1; c.busy = 1'b1;
            end
            S_DN: begin
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State, mode capture and outputs registered together so outputs track the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= next_of(state_q, start, mode_q);
            ctrl_q  <= decode(next_of(state_q, start, mode_q));
            if (state_q == S_IDLE && start) begin
                mode_q <= MODE_W'(mode);
            end
        end
    end

    assign m0   = ctrl_q.m0;
    assign m1   = ctrl_q.m1;
    assign m2   = ctrl_q.m2;
    assign h    = ctrl_q.h;
    assign lx   = ctrl_q.lx;
    assign ls   = ctrl_q.ls;
    assign lh   = ctrl_q.lh;
    assign busy = ctrl_q.busy;
    assign done = ctrl_q.done;

endmodule

// File: tb/tb_bloco_controle.sv
// Testbench for bloco_controle: pairs the FSM with a behavioural 16-bit datapath,
// checks per-cycle control vectors and the final S value against the polynomial.
module tb_bloco_controle;

    logic clk = 1'b0;
    logic rst_n, start, mode;
    logic [1:0] m0, m1, m2;
    logic h, lx, ls, lh, busy, done;

    logic signed [15:0] a, b, c;
    logic [7:0]         x;
    logic signed [15:0] xr, sr, hr;
    logic signed [15:0] mux0, opa, opb, alu;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [15:0] exp_q[$];

    logic [11:0] vec;
    assign vec = {m0, m1, m2, h, lx, ls, lh, busy, done};

    // Expected vectors {m0,m1,m2,h,lx,ls,lh,busy,done}
    localparam logic [11:0] V_LX = 12'b000000_010010;
    localparam logic [11:0] V_M1 = 12'b000000_101010;
    localparam logic [11:0] V_A1 = 12'b101001_001010;
    localparam logic [11:0] V_M2 = 12'b001000_101010;
    localparam logic [11:0] V_A2 = 12'b111001_001010;
    localparam logic [11:0] V_HM = 12'b000000_100110;
    localparam logic [11:0] V_SM = 12'b110000_101010;
    localparam logic [11:0] V_FM = 12'b001011_101010;
    localparam logic [11:0] V_DN = 12'b000000_000001;

    always #5 clk = ~clk;

    bloco_controle dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .m0(m0), .m1(m1), .m2(m2), .h(h),
        .lx(lx), .ls(ls), .lh(lh), .busy(busy), .done(done)
    );

    // Behavioural datapath
    always_comb begin
        case (m0)
            2'd2:    mux0 = b;
            2'd3:    mux0 = c;
            default: mux0 = a;
        endcase
        case (m1)
            2'd0:    opa = mux0;
            2'd1:    opa = xr;
            2'd2:    opa = sr;
            default: opa = hr;
        endcase
        case (m2)
            2'd0:    opb = xr;
            2'd1:    opb = mux0;
            2'd2:    opb = sr;
            default: opb = hr;
        endcase
        alu = h ? 16'(opa * opb) : 16'(opa + opb);
    end

    always_ff @(posedge clk) begin
        if (lx) xr <= {{8{x[7]}}, x};
        if (ls) sr <= alu;
        if (lh) hr <= alu;
    end

    function automatic logic signed [15:0] model(input bit md, input int av, input int bv,
                                                 input int cv, input int xv);
        if (md) return 16'(av * cv * xv * xv);
        return 16'(av * xv * xv + bv * xv + cv);
    endfunction

    function automatic logic signed [15:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Drives one start pulse from IDLE; returns #1 after the accepting edge.
    task automatic start_run(input bit md, input logic signed [15:0] av, input logic signed [15:0] bv,
                             input logic signed [15:0] cv, input logic [7:0] xv);
        @(negedge clk);
        a = av; b = bv; c = cv; x = xv; mode = md; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(md, av, bv, cv, $signed(xv)));
        #1 start = 1'b0;
    endtask

    // Cycle index (negedges after the accepting edge, starting at first) where done is seen.
    task automatic wait_done(input int first, output int lat);
        lat = -1;
        for (int i = first; i < first + 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; mode = 1'b0;
        a = '0; b = '0; c = '0; x = '0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (vec !== 12'h000) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", vec, 12'h000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (vec !== 12'h000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", vec, 12'h000);
        end
    endtask

    task automatic test_mode0();
        logic [11:0] seq [6];
        logic signed [15:0] e;
        int busy_cnt;
        seq = '{V_LX, V_M1, V_A1, V_M2, V_A2, V_DN};
        busy_cnt = 0;
        start_run(1'b0, 16'sd2, 16'sd3, 16'sd4, 8'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            n_checks++;
            if (vec !== seq[i]) begin
                n_fail++; $display("FAIL mode0_vec[%0d]: got %b expected %b", i, vec, seq[i]);
            end
        end
        e = pop_exp();
        n_checks++;
        if (sr !== e) begin
            n_fail++; $display("FAIL mode0_result: got %0d expected %0d", sr, e);
        end
        n_checks++;
        if (busy_cnt != 5) begin
            n_fail++; $display("FAIL mode0_busy_cycles: got %0d expected 5", busy_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (vec !== 12'h000) begin
            n_fail++; $display("FAIL mode0_back_idle: got %b expected %b", vec, 12'h000);
        end
    endtask

    task automatic test_mode1();
        logic [11:0] seq [5];
        logic signed [15:0] e;
        seq = '{V_LX, V_HM, V_SM, V_FM, V_DN};
        start_run(1'b1, 16'sd2, 16'sd0, 16'sd4, 8'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (vec !== seq[i]) begin
                n_fail++; $display("FAIL mode1_vec[%0d]: got %b expected %b", i, vec, seq[i]);
            end
        end
        e = pop_exp();
        n_checks++;
        if (sr !== e) begin
            n_fail++; $display("FAIL mode1_result: got %0d expected %0d", sr, e);
        end
        @(negedge clk);
    endtask

    task automatic test_arith(input logic signed [15:0] av, input logic signed [15:0] bv,
                              input logic signed [15:0] cv, input logic [7:0] xv);
        int lat;
        logic signed [15:0] e;
        start_run(1'b0, av, bv, cv, xv);
        wait_done(0, lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++; $display("FAIL arith_latency: got %0d expected 5", lat);
        end
        e = pop_exp();
        n_checks++;
        if (sr !== e) begin
            n_fail++; $display("FAIL arith_result x=%h: got %0d expected %0d", xv, sr, e);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int dones;
        logic signed [15:0] e, got;
        dones = 0;
        got = '0;
        start_run(1'b0, 16'sd5, -16'sd2, 16'sd7, 8'd3);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) got = sr;
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL ignore_start_dones: got %0d expected 1", dones);
        end
        e = pop_exp();
        n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL ignore_start_result: got %0d expected %0d", got, e);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic signed [15:0] e;
        start_run(1'b0, 16'sd3, -16'sd1, 16'sd10, 8'hFE);
        repeat (5) @(negedge clk);
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done);
        end
        e = pop_exp();
        n_checks++;
        if (sr !== e) begin
            n_fail++; $display("FAIL b2b_first_result: got %0d expected %0d", sr, e);
        end
        a = -16'sd3; b = 16'sd0; c = 16'sd7; x = 8'd6;
        @(negedge clk);
        n_checks++;
        if (vec !== 12'h000) begin
            n_fail++; $display("FAIL b2b_idle_gap: got %b expected %b", vec, 12'h000);
        end
        @(posedge clk);
        exp_q.push_back(model(1'b1, a, b, c, $signed(x)));
        @(negedge clk);
        n_checks++;
        if (vec !== V_LX) begin
            n_fail++; $display("FAIL b2b_second_accept: got %b expected %b", vec, V_LX);
        end
        start = 1'b0;
        wait_done(1, lat);
        n_checks++;
        if (lat != 4) begin
            n_fail++; $display("FAIL b2b_second_latency: got %0d expected 4", lat);
        end
        e = pop_exp();
        n_checks++;
        if (sr !== e) begin
            n_fail++; $display("FAIL b2b_second_result: got %0d expected %0d", sr, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_run(1'b0, 16'sd2, 16'sd3, 16'sd4, 8'd5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (vec !== 12'h000) begin
            n_fail++; $display("FAIL reset_mid_async: got %b expected %b", vec, 12'h000);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (vec !== 12'h000) begin
                n_fail++; $display("FAIL reset_mid_stay_idle[%0d]: got %b expected %b", i, vec, 12'h000);
            end
        end
        test_arith(-16'sd7, 16'sd11, -16'sd100, 8'h0C);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_arith(16'sd1, 16'sd0, 16'sd0, 8'hFD);
        test_arith(16'sd300, 16'sd0, 16'sd0, 8'd100);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
